wb_mem_resp: RTL and testbench
==============================

WB_MEM_RESP -- requirements
Module: wb_mem_resp

Interface
REQ-001 SHALL have parameter DW, default 64, Wishbone data width (32 or 64 only).
REQ-002 SHALL have parameter MAW, default 10, log2 of memory depth in DW-wide words.
REQ-003 SHALL have parameter WAIT, default 0, wait states per beat (0..15).
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wbs_cyc_i  in  1  bus cycle.
REQ-007 SHALL have port wbs_stb_i  in  1  strobe.
REQ-008 SHALL have port wbs_we_i  in  1  write enable.
REQ-009 SHALL have port wbs_cab_i  in  1  consecutive-address burst.
REQ-010 SHALL have port wbs_adr_i  in  32  byte address.
REQ-011 SHALL have port wbs_sel_i  in  DW/8  byte lane enables.
REQ-012 SHALL have port wbs_dat_i  in  DW  write data.
REQ-013 SHALL have port wbs_dat_o  out  DW  read data, registered.
REQ-014 SHALL have port wbs_ack_o  out  1  normal termination, registered.
REQ-015 SHALL have port wbs_err_o  out  1  error termination, registered.
REQ-016 SHALL have port wbs_rty_o  out  1  retry, constant 0.
REQ-017 SHALL have port beat_cnt_o  out  16  acked beats in current cycle.

Function
REQ-018 Word index SHALL be wbs_adr_i[MAW+L-1:L], L=log2(DW/8); upper bits ignored (modulo depth).
REQ-019 FSM states SHALL be IDLE, WAIT, ACK; IDLE exits when cyc&stb sampled high.
REQ-020 On IDLE exit, word index SHALL latch into internal address and wait counter SHALL load WAIT.
REQ-021 WAIT>0: IDLE->WAIT, counter decrements per cycle, WAIT->ACK when counter reaches 1; WAIT=0: IDLE->ACK directly.
REQ-022 wbs_ack_o SHALL be high exactly one cycle per beat, WAIT+1 cycles after request sampled.
REQ-023 Writes SHALL commit on the ack edge, only bytes with wbs_sel_i set; unselected bytes unchanged.
REQ-024 Read data SHALL be valid in the same cycle as wbs_ack_o and held until next ack.
REQ-025 Burst: if wbs_cab_i=1 and cyc&stb high during ACK, internal address SHALL increment by one word (wrapping at depth) and FSM SHALL reload counter without returning to IDLE; wbs_adr_i ignored after first beat.
REQ-026 WAIT=0 burst SHALL ack every cycle; non-cab accesses SHALL return to IDLE after ack (min 2 cycles/beat).
REQ-027 cyc low in WAIT or ACK SHALL abort: FSM to IDLE next cycle, no write, no ack.
REQ-028 beat_cnt_o SHALL increment per ack, saturate at 16'hFFFF, clear when wbs_cyc_i low.
REQ-029 Ack and err SHALL never be high simultaneously.

Reset
REQ-030 wb_rst_i low SHALL immediately force FSM to IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, beat_cnt_o=0, counter=0.
REQ-031 Memory contents SHALL NOT be cleared by reset; reset mid-burst SHALL drop pending beat with no write.

Configuration
REQ-032 Macro WB_MEM_ERR_INJ_EN defined: ports err_en_i (in, 1) and err_adr_i (in, 32) SHALL exist; beat whose word index equals err_adr_i word index while err_en_i=1 SHALL give wbs_err_o instead of ack, no write, burst terminated to IDLE, beat_cnt_o unchanged.
REQ-033 Macro undefined: those ports SHALL be absent and wbs_err_o SHALL be constant 0.

Verification
REQ-034 DW=64, WAIT=0: write 64'h0000_0300_0000_0200 to adr 0x0, sel 8'hFF, then read 0x0 -> ack 1 cycle after stb, dat_o=64'h0000_0300_0000_0200.
REQ-035 WAIT=3: single read -> ack exactly 4 cycles after request; beat_cnt_o=1; clears to 0 after cyc drops.
REQ-036 Burst cab=1, WAIT=0, start 0x8, 4 beats, cyc held -> acks on 4 consecutive cycles, data of words 1..4, beat_cnt_o=4.
REQ-037 Partial write sel=8'h0F data 64'hFFFF_FFFF_FFFF_FFFF over 64'h0 -> readback 64'h0000_0000_FFFF_FFFF.
REQ-038 MAW=10 burst from last word 0x1FF8, 2 beats -> second beat returns word 0 (wrap).
REQ-039 WB_MEM_ERR_INJ_EN, err_adr_i=0x10, burst from 0x0 -> acks beats 0,1, err on beat 2, no further ack, word 2 unchanged; cyc dropped during WAIT=3 -> no ack, no write.

Source files
------------

// File: rtl/wb_mem_resp.sv
// wb_mem_resp: Wishbone slave memory with configurable wait states and
// consecutive-address (cab) burst support.
//
// Parameters:
//   DW   - data width, 32 or 64
//   MAW  - log2 of memory depth in DW-wide words
//   WAIT - wait states inserted before each beat (0..15)
//
// Ports:
//   wb_clk_i   - clock, all logic on the rising edge
//   wb_rst_i   - asynchronous active-low reset (memory contents are kept)
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i - Wishbone cycle controls
//   wbs_adr_i  - byte address; word index is adr[MAW+L-1:L], L = log2(DW/8)
//   wbs_sel_i  - byte lane enables for writes
//   wbs_dat_i  - write data
//   wbs_dat_o  - registered read data, valid with ack and held until next ack
//   wbs_ack_o  - registered normal termination, one cycle per beat
//   wbs_err_o  - registered error termination (0 unless injection is built in)
//   wbs_rty_o  - retry, constant 0
//   beat_cnt_o - acked beats in the current cycle, saturating, cleared when cyc is low
//
// Optional build macro WB_MEM_ERR_INJ_EN adds err_en_i / err_adr_i: a beat whose
// word index matches err_adr_i while err_en_i is high terminates with err,
// performs no write, leaves beat_cnt_o unchanged and ends the burst.

module wb_mem_resp #(
    parameter int unsigned DW   = 64,
    parameter int unsigned MAW  = 10,
    parameter int unsigned WAIT = 0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic            wbs_cab_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [DW/8-1:0] wbs_sel_i,
    input  logic [DW-1:0]   wbs_dat_i,
`ifdef WB_MEM_ERR_INJ_EN
    input  logic            err_en_i,
    input  logic [31:0]     err_adr_i,
`endif
    output logic [DW-1:0]   wbs_dat_o,
    output logic            wbs_ack_o,
    output logic            wbs_err_o,
    output logic            wbs_rty_o,
    output logic [15:0]     beat_cnt_o
);

    localparam int unsigned L     = $clog2(DW / 8);
    localparam int unsigned Depth = 1 << MAW;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e          state_q, state_d;
    logic [MAW-1:0]  addr_q, addr_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [15:0]     beat_cnt_q, beat_cnt_d;

    logic            mem_we;
    logic            enter_ack;
    logic            req;
    logic [MAW-1:0]  adr_idx;

    logic [DW-1:0]   mem [Depth];

    assign req     = wbs_cyc_i && wbs_stb_i;
    assign adr_idx = wbs_adr_i[MAW+L-1:L];

    // Address bits outside the word index are deliberately ignored.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:MAW+L], wbs_adr_i[L-1:0]};

`ifdef WB_MEM_ERR_INJ_EN
    logic unused_err_adr;
    assign unused_err_adr = ^{err_adr_i[31:MAW+L], err_adr_i[L-1:0]};
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = dat_q;
        beat_cnt_d = beat_cnt_q;
        mem_we     = 1'b0;
        enter_ack  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d     = adr_idx;
                    wait_cnt_d = 4'(WAIT);
                    if (WAIT == 0) begin
                        enter_ack = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!wbs_cyc_i) begin
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q <= 4'd1) begin
                        enter_ack = 1'b1;
                    end
                end
            end
            StAck: begin
                // The beat completes on the edge closing the ack cycle, which is
                // when the master samples ack; an error beat never writes.
                state_d = StIdle;
                if (req && !err_q) begin
                    mem_we = wbs_we_i;
                    if (wbs_cab_i) begin
                        addr_d     = addr_q + MAW'(1);
                        wait_cnt_d = 4'(WAIT);
                        if (WAIT == 0) begin
                            enter_ack = 1'b1;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // addr_d holds the word index of the beat about to be terminated.
        if (enter_ack) begin
            state_d = StAck;
`ifdef WB_MEM_ERR_INJ_EN
            err_d = err_en_i && (err_adr_i[MAW+L-1:L] == addr_d);
`endif
            if (!err_d) begin
                ack_d = 1'b1;
                dat_d = mem[addr_d];
                if (beat_cnt_q != 16'hFFFF) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                end
            end
        end

        if (!wbs_cyc_i) begin
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wait_cnt_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Storage is not reset; reset only forces the FSM idle, which blocks mem_we.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (wbs_sel_i[b]) begin
                    mem[addr_q][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wbs_dat_o  = dat_q;
    assign wbs_ack_o  = ack_q;
    assign wbs_rty_o  = 1'b0;
    assign beat_cnt_o = beat_cnt_q;

`ifdef WB_MEM_ERR_INJ_EN
    assign wbs_err_o = err_q;
`else
    assign wbs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mem_resp.sv
module tb_wb_mem_resp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WAIT=0 instance, index 1: WAIT=3 instance.
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic        cab [2];
    logic [31:0] adr [2];
    logic [7:0]  sel [2];
    logic [63:0] dat_i [2];
    logic [63:0] dat_o [2];
    logic        ack [2];
    logic        err [2];
    logic        rty [2];
    logic [15:0] beat [2];
`ifdef WB_MEM_ERR_INJ_EN
    logic        err_en [2];
    logic [31:0] err_adr [2];
`endif

    logic [63:0] model [2][1024];
    logic [63:0] wbuf [16];

    int checks = 0;
    int errors = 0;

    wb_mem_resp #(.DW(64), .MAW(10), .WAIT(0)) dut0 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wbs_cyc_i  (cyc[0]),
        .wbs_stb_i  (stb[0]),
        .wbs_we_i   (we[0]),
        .wbs_cab_i  (cab[0]),
        .wbs_adr_i  (adr[0]),
        .wbs_sel_i  (sel[0]),
        .wbs_dat_i  (dat_i[0]),
`ifdef WB_MEM_ERR_INJ_EN
        .err_en_i   (err_en[0]),
        .err_adr_i  (err_adr[0]),
`endif
        .wbs_dat_o  (dat_o[0]),
        .wbs_ack_o  (ack[0]),
        .wbs_err_o  (err[0]),
        .wbs_rty_o  (rty[0]),
        .beat_cnt_o (beat[0])
    );

    wb_mem_resp #(.DW(64), .MAW(10), .WAIT(3)) dut3 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wbs_cyc_i  (cyc[1]),
        .wbs_stb_i  (stb[1]),
        .wbs_we_i   (we[1]),
        .wbs_cab_i  (cab[1]),
        .wbs_adr_i  (adr[1]),
        .wbs_sel_i  (sel[1]),
        .wbs_dat_i  (dat_i[1]),
`ifdef WB_MEM_ERR_INJ_EN
        .err_en_i   (err_en[1]),
        .err_adr_i  (err_adr[1]),
`endif
        .wbs_dat_o  (dat_o[1]),
        .wbs_ack_o  (ack[1]),
        .wbs_err_o  (err[1]),
        .wbs_rty_o  (rty[1]),
        .beat_cnt_o (beat[1])
    );

    function automatic int wt(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        cyc[d]   = 1'b0;
        stb[d]   = 1'b0;
        we[d]    = 1'b0;
        cab[d]   = 1'b0;
        adr[d]   = '0;
        sel[d]   = '0;
        dat_i[d] = '0;
    endtask

    // Runs an n-beat access (cab burst when n>1) starting at byte address a;
    // write data comes from wbuf, reads are compared against the model.
    task automatic burst(input int d, input logic w, input logic [31:0] a, input int n,
                         input logic [7:0] s);
        int nack;
        int edges;
        int gap;
        int word;
        int last_word;
        nack = 0;
        edges = 0;
        gap = 0;
        last_word = 0;
        cyc[d] = 1'b1;
        stb[d] = 1'b1;
        we[d] = w;
        cab[d] = (n > 1);
        adr[d] = a;
        sel[d] = s;
        dat_i[d] = wbuf[0];
        while (nack < n && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            gap++;
            adr[d] = $urandom;  // address must be ignored after the first beat
            dat_i[d] = wbuf[nack];
            cab[d] = (nack != n - 1);
            if (ack[d]) begin
                word = (int'(a[12:3]) + nack) % 1024;
                check("beat_latency", 64'(gap), 64'(wt(d) + 1));
                check("beat_cnt", 64'(beat[d]), 64'(nack + 1));
                check("err_with_ack", 64'(err[d]), 64'd0);
                check("rty_const", 64'(rty[d]), 64'd0);
                if (w) begin
                    for (int b = 0; b < 8; b++) begin
                        if (s[b]) model[d][word][8*b +: 8] = wbuf[nack][8*b +: 8];
                    end
                end else begin
                    check("rdata", dat_o[d], model[d][word]);
                end
                last_word = word;
                nack++;
                gap = 0;
            end
        end
        if (nack != n) check("burst_timeout", 64'(nack), 64'(n));
        @(posedge clk);
        #1;
        check("ack_single_cycle", 64'(ack[d]), 64'd0);
        if (!w) check("rdata_held", dat_o[d], model[d][last_word]);
        bus_idle(d);
        @(posedge clk);
        #1;
        check("beat_cnt_clear", 64'(beat[d]), 64'd0);
    endtask

    initial begin
        int seen;
        int edges;
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
`ifdef WB_MEM_ERR_INJ_EN
            err_en[d] = 1'b0;
            err_adr[d] = '0;
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_dat", dat_o[d], 64'd0);
            check("rst_ack", 64'(ack[d]), 64'd0);
            check("rst_err", 64'(err[d]), 64'd0);
            check("rst_beat", 64'(beat[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full write then read of word 0 on the zero-wait instance.
        wbuf[0] = 64'h0000_0300_0000_0200;
        burst(0, 1'b1, 32'h0, 1, 8'hFF);
        burst(0, 1'b0, 32'h0, 1, 8'hFF);
        check("wr_rd_word0", dat_o[0], 64'h0000_0300_0000_0200);

        // Fill words 0..15 and the last word of both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = {$urandom, $urandom};
            burst(d, 1'b1, 32'h0, 16, 8'hFF);
            wbuf[0] = {$urandom, $urandom};
            burst(d, 1'b1, 32'h1FF8, 1, 8'hFF);
        end

        // Four-beat read burst from 0x8: words 1..4.
        burst(0, 1'b0, 32'h8, 4, 8'hFF);

        // Partial write of the low four lanes over zero.
        wbuf[0] = 64'h0;
        burst(0, 1'b1, 32'h48, 1, 8'hFF);
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        burst(0, 1'b1, 32'h48, 1, 8'h0F);
        burst(0, 1'b0, 32'h48, 1, 8'hFF);
        check("partial_write", dat_o[0], 64'h0000_0000_FFFF_FFFF);

        // Burst from the last word wraps to word 0.
        burst(0, 1'b0, 32'h1FF8, 2, 8'hFF);
        check("wrap_word0", dat_o[0], model[0][0]);

        // Three-wait single read.
        burst(1, 1'b0, 32'h20, 1, 8'hFF);

        // Cycle dropped during wait states: no ack, no write.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h28;
        sel[1] = 8'hFF; dat_i[1] = ~model[1][5];
        repeat (2) @(posedge clk);
        #1;
        bus_idle(1);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack[1]) seen = 1;
        end
        check("abort_no_ack", 64'(seen), 64'd0);
        burst(1, 1'b0, 32'h28, 1, 8'hFF);

        // Reset asserted during an ack cycle: outputs clear at once, no write.
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30;
        sel[1] = 8'hFF; dat_i[1] = ~model[1][6];
        edges = 0;
        while (!ack[1] && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("rst_test_ack", 64'(ack[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", 64'(ack[1]), 64'd0);
        check("async_rst_dat", dat_o[1], 64'd0);
        check("async_rst_beat", 64'(beat[1]), 64'd0);
        bus_idle(1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        burst(1, 1'b0, 32'h30, 1, 8'hFF);

`ifdef WB_MEM_ERR_INJ_EN
        // Error injected on word 2 of a write burst from 0x0.
        begin
            int nack;
            int got;
            err_en[0] = 1'b1;
            err_adr[0] = 32'h10;
            for (int i = 0; i < 4; i++) wbuf[i] = {$urandom, $urandom};
            cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; cab[0] = 1'b1;
            adr[0] = 32'h0; sel[0] = 8'hFF; dat_i[0] = wbuf[0];
            nack = 0;
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                @(posedge clk);
                #1;
                dat_i[0] = wbuf[nack];
                if (ack[0]) begin
                    model[0][nack] = wbuf[nack];
                    nack++;
                end
                if (err[0]) begin
                    got = 1;
                    check("err_and_ack", 64'(ack[0]), 64'd0);
                    check("err_beat_cnt", 64'(beat[0]), 64'd2);
                    bus_idle(0);
                end
            end
            check("err_seen", 64'(got), 64'd1);
            check("acks_before_err", 64'(nack), 64'd2);
            @(posedge clk);
            #1;
            check("after_err_quiet", 64'(ack[0] | err[0]), 64'd0);
            err_en[0] = 1'b0;
            @(posedge clk);
            #1;
            burst(0, 1'b0, 32'h0, 4, 8'hFF);
        end
`endif

        // Random single/burst traffic confined to words 0..15.
        for (int it = 0; it < 60; it++) begin
            int d;
            int n;
            int st;
            logic [31:0] a;
            d = it % 2;
            n = $urandom_range(1, 3);
            st = $urandom_range(0, 13);
            a = ($urandom & 32'hFFFF_E000) | 32'(st << 3) | 32'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) wbuf[i] = {$urandom, $urandom};
            burst(d, 1'($urandom_range(0, 1)), a, n, 8'($urandom));
        end

        for (int d = 0; d < 2; d++) burst(d, 1'b0, 32'h0, 16, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
